// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, decoded operation classes, decode-stage states
// and the source-operand usage rules.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] OPC_LUI    = 4'd0;
    localparam logic [3:0] OPC_AUIPC  = 4'd1;
    localparam logic [3:0] OPC_JAL    = 4'd2;
    localparam logic [3:0] OPC_JALR   = 4'd3;
    localparam logic [3:0] OPC_BRANCH = 4'd4;
    localparam logic [3:0] OPC_LOAD   = 4'd5;
    localparam logic [3:0] OPC_STORE  = 4'd6;
    localparam logic [3:0] OPC_OPIMM  = 4'd7;
    localparam logic [3:0] OPC_OP     = 4'd8;
    localparam logic [3:0] OPC_FENCE  = 4'd9;
    localparam logic [3:0] OPC_SYSTEM = 4'd10;
    localparam logic [3:0] OPC_ILL    = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BEF = 2'd1,
        ST_DECODE   = 2'd2,
        ST_SENDING  = 2'd3
    } dec_state_t;

    function automatic logic uses_rs1(input logic [3:0] opc);
        return opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    endfunction

    function automatic logic uses_rs2(input logic [3:0] opc);
        return opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

    // Branches and stores have no destination; illegal words are squashed to x0.
    function automatic logic writes_rd(input logic [3:0] opc);
        return !(opc inside {OPC_BRANCH, OPC_STORE, OPC_ILL});
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I classifier: instruction word -> sign-extended immediate,
// operation class and illegal flag.
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      opclass,
    output logic            illegal
);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm32;

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Every valid opcode ends in 2'b11, so compressed encodings fall to the default.
    always_comb begin
        opclass = OPC_ILL;
        imm32   = '0;
        case (instr[6:0])
            OP_LUI:    begin opclass = OPC_LUI;    imm32 = u_imm; end
            OP_AUIPC:  begin opclass = OPC_AUIPC;  imm32 = u_imm; end
            OP_JAL:    begin opclass = OPC_JAL;    imm32 = j_imm; end
            OP_JALR:   begin opclass = OPC_JALR;   imm32 = i_imm; end
            OP_BRANCH: begin opclass = OPC_BRANCH; imm32 = b_imm; end
            OP_LOAD:   begin opclass = OPC_LOAD;   imm32 = i_imm; end
            OP_STORE:  begin opclass = OPC_STORE;  imm32 = s_imm; end
            OP_OPIMM:  begin opclass = OPC_OPIMM;  imm32 = i_imm; end
            OP_OP:     begin opclass = OPC_OP;     imm32 = '0;    end
            OP_FENCE:  begin opclass = OPC_FENCE;  imm32 = i_imm; end
            OP_SYSTEM: begin opclass = OPC_SYSTEM; imm32 = i_imm; end
            default:   ;
        endcase
    end

    assign illegal = (opclass == OPC_ILL);
    assign imm     = XLEN'($signed(imm32));

endmodule

// File: rtl/decode.sv
// RV32I decode stage: handshakes with fetch, reads the regfile, stalls on scoreboard
// hazards and hands a registered bundle to execute.
module decode
    import rv32_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int READ_ADDR_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      startSig,
    input  logic                      interrupt_start,
    input  logic                      beforePipReadyToSend,
    input  logic                      nextPipReadyToRcv,
    input  logic [XLEN-1:0]           fetch_data,
    input  logic [READ_ADDR_SIZE-1:0] fetch_cur_pc,
    input  logic [READ_ADDR_SIZE-1:0] fetch_nxt_pc,
    output logic [4:0]                rf_rs1_addr,
    output logic [4:0]                rf_rs2_addr,
    input  logic [XLEN-1:0]           rf_rs1_data,
    input  logic [XLEN-1:0]           rf_rs2_data,
    input  logic [31:0]               wb_busy_mask,
    output logic [READ_ADDR_SIZE-1:0] dec_pc,
    output logic [READ_ADDR_SIZE-1:0] dec_nxt_pc,
    output logic [XLEN-1:0]           dec_imm,
    output logic [XLEN-1:0]           dec_rs1_val,
    output logic [XLEN-1:0]           dec_rs2_val,
    output logic [4:0]                dec_rd,
    output logic [3:0]                dec_opclass,
    output logic [2:0]                dec_funct3,
    output logic                      dec_funct7b5,
    output logic                      dec_illegal,
    output logic                      curPipReadyToRcv,
    output logic                      curPipReadyToSend
);

    dec_state_t      state;
    logic [XLEN-1:0] imm;
    logic [3:0]      opclass;
    logic            illegal;
    logic            hazard;
    logic            restart;
    logic [4:0]      rd;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (fetch_data[31:0]),
        .imm     (imm),
        .opclass (opclass),
        .illegal (illegal)
    );

    assign rf_rs1_addr = fetch_data[19:15];
    assign rf_rs2_addr = fetch_data[24:20];
    assign rd          = writes_rd(opclass) ? fetch_data[11:7] : 5'd0;

    // x0 is hard-wired, so a pending write to it can never block a read.
    assign hazard = (uses_rs1(opclass) && (rf_rs1_addr != 5'd0) && wb_busy_mask[rf_rs1_addr])
                 || (uses_rs2(opclass) && (rf_rs2_addr != 5'd0) && wb_busy_mask[rf_rs2_addr]);

    assign restart           = startSig | interrupt_start;
    assign curPipReadyToSend = (state == ST_SENDING) & ~interrupt_start;
    assign curPipReadyToRcv  = (state == ST_WAIT_BEF) | (curPipReadyToSend & nextPipReadyToRcv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dec_pc       <= '0;
            dec_nxt_pc   <= '0;
            dec_imm      <= '0;
            dec_rs1_val  <= '0;
            dec_rs2_val  <= '0;
            dec_rd       <= '0;
            dec_opclass  <= '0;
            dec_funct3   <= '0;
            dec_funct7b5 <= 1'b0;
            dec_illegal  <= 1'b0;
        end else if (restart) begin
            // Leaving SENDING drops the held bundle: it is never offered again.
            state <= beforePipReadyToSend ? ST_DECODE : ST_WAIT_BEF;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_WAIT_BEF: begin
                    if (beforePipReadyToSend) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (!hazard) begin
                        dec_pc       <= fetch_cur_pc;
                        dec_nxt_pc   <= fetch_nxt_pc;
                        dec_imm      <= imm;
                        dec_rs1_val  <= rf_rs1_data;
                        dec_rs2_val  <= rf_rs2_data;
                        dec_rd       <= rd;
                        dec_opclass  <= opclass;
                        dec_funct3   <= fetch_data[14:12];
                        dec_funct7b5 <= fetch_data[30];
                        dec_illegal  <= illegal;
                        state        <= ST_SENDING;
                    end
                end
                ST_SENDING: begin
                    if (nextPipReadyToRcv)
                        state <= beforePipReadyToSend ? ST_DECODE : ST_WAIT_BEF;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
